// File: rtl/s2p_pkg.sv
// Shared definitions for the serial-to-parallel aligner: lock FSM state
// encodings and the default line symbols.
package s2p_pkg;

    // Lock FSM states: hunting for a comma, confirming its phase, locked.
    typedef enum logic [1:0] {
        S2P_SEARCH = 2'd0,
        S2P_ALIGN  = 2'd1,
        S2P_ACTIVE = 2'd2
    } s2p_state_e;

    // Default alignment symbol (K28.5-style comma) and idle filler symbol.
    localparam logic [7:0] S2P_DEFAULT_COMMA = 8'hBC;
    localparam logic [7:0] S2P_DEFAULT_IDLE  = 8'h7C;

endpackage

// File: rtl/s2p_shift_align.sv
// Serial shift register with word-phase counter. Exposes the current window,
// a boundary strobe (window is an aligned word) and a comma compare.
module s2p_shift_align
    import s2p_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = WIDTH'(S2P_DEFAULT_COMMA)
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    input  logic             realign,
    output logic [WIDTH-1:0] sr,
    output logic             boundary,
    output logic             comma_hit
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] bit_cnt;

    // Shift one bit in per clock, MSB first; a realign request makes the
    // current window the word boundary so the next one lands WIDTH clocks on.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr <= {sr[WIDTH-2:0], data_in};
            if (realign) begin
                bit_cnt <= CW'(1);
            end else if (bit_cnt == CW'(WIDTH - 1)) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    assign boundary  = (bit_cnt == '0);
    assign comma_hit = (sr == COMMA);

endmodule

// File: rtl/serial_paralelo_align.sv
// Serial-to-parallel converter with comma-based word alignment.
// Optional feature macro: S2P_RELOCK_EN -- when defined, repeated misaligned
// commas while locked drop lock and restart the comma hunt; when undefined,
// lock is left only through reset.
module serial_paralelo_align
    import s2p_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = WIDTH'(S2P_DEFAULT_COMMA),
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int CCW = $clog2(LOCK_COUNT + 1);

    s2p_state_e       state;
    logic [CCW-1:0]   comma_cnt;
    logic [WIDTH-1:0] sr;
    logic             boundary;
    logic             comma_hit;
    logic             realign;

    // While hunting, any comma (at any bit phase) defines the new word phase.
    assign realign = (state == S2P_SEARCH) && comma_hit;

    s2p_shift_align #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_shift (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .realign   (realign),
        .sr        (sr),
        .boundary  (boundary),
        .comma_hit (comma_hit)
    );

`ifdef S2P_RELOCK_EN
    localparam int LW = $clog2(LOSS_COUNT + 1);

    logic [LW-1:0] loss_cnt;
    logic          misaligned_seen;
    logic          loss_trip;

    // A flagged word that would complete the run of LOSS_COUNT drops lock.
    assign loss_trip = (state == S2P_ACTIVE) && boundary && misaligned_seen &&
                       (int'(loss_cnt) + 1 >= LOSS_COUNT);

    // Track commas seen off the word boundary and count consecutive flagged words.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            misaligned_seen <= 1'b0;
            loss_cnt        <= '0;
        end else if (state != S2P_ACTIVE) begin
            misaligned_seen <= 1'b0;
            loss_cnt        <= '0;
        end else if (boundary) begin
            misaligned_seen <= 1'b0;
            if (!misaligned_seen || loss_trip) begin
                loss_cnt <= '0;
            end else begin
                loss_cnt <= loss_cnt + LW'(1);
            end
        end else if (comma_hit) begin
            misaligned_seen <= 1'b1;
        end
    end
`endif

    // Lock FSM with registered outputs: hunt, confirm LOCK_COUNT aligned
    // commas, then publish one word per boundary while locked.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= S2P_SEARCH;
            comma_cnt <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            case (state)
                S2P_SEARCH: begin
                    valid_out <= 1'b0;
                    if (comma_hit) begin
                        comma_cnt <= CCW'(1);
                        if (LOCK_COUNT == 1) begin
                            state  <= S2P_ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= S2P_ALIGN;
                        end
                    end
                end
                S2P_ALIGN: begin
                    valid_out <= 1'b0;
                    if (boundary) begin
                        if (comma_hit) begin
                            comma_cnt <= comma_cnt + CCW'(1);
                            if (int'(comma_cnt) + 1 >= LOCK_COUNT) begin
                                state  <= S2P_ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            comma_cnt <= '0;
                            state     <= S2P_SEARCH;
                        end
                    end
                end
                S2P_ACTIVE: begin
                    if (boundary) begin
`ifdef S2P_RELOCK_EN
                        if (loss_trip) begin
                            state     <= S2P_SEARCH;
                            comma_cnt <= '0;
                            valid_out <= 1'b0;
                            active    <= 1'b0;
                        end else begin
                            data_out  <= sr;
                            valid_out <= !comma_hit;
                        end
`else
                        data_out  <= sr;
                        valid_out <= !comma_hit;
`endif
                    end
                end
                default: begin
                    state     <= S2P_SEARCH;
                    comma_cnt <= '0;
                    valid_out <= 1'b0;
                    active    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Self-checking bench for serial_paralelo_align: a default 8-bit instance and
// a 10-bit / COMMA=17C / LOCK_COUNT=2 instance, both checked every clock
// against a word-phase reference model. Relock scenario runs with S2P_RELOCK_EN.
module tb_serial_paralelo_align;

    localparam int LOSS = 2;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data8   = 1'b0;
    logic       data10  = 1'b0;
    logic [7:0] dout8;
    logic       valid8, active8;
    logic [9:0] dout10;
    logic       valid10, active10;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = 8-bit instance, 1 = 10-bit instance.
    int          p_w     [2] = '{8, 10};
    logic [15:0] p_comma [2] = '{16'h00BC, 16'h017C};
    int          p_lock  [2] = '{4, 2};
    int          m_state [2];
    logic [15:0] m_word  [2];
    logic [15:0] m_dout  [2];
    int          m_edge  [2];
    int          m_anchor[2];
    int          m_cnt   [2];
    int          m_loss  [2];
    bit          m_flag  [2];
    bit          m_val   [2];
    bit          m_act   [2];

    bit q8 [$];
    bit q10[$];

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_align dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data8),
        .data_out  (dout8),
        .valid_out (valid8),
        .active    (active8)
    );

    serial_paralelo_align #(
        .WIDTH      (10),
        .COMMA      (10'h17C),
        .LOCK_COUNT (2),
        .LOSS_COUNT (2)
    ) dut10 (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data10),
        .data_out  (dout10),
        .valid_out (valid10),
        .active    (active10)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;  m_word[i] = '0;  m_dout[i] = '0;
            m_edge[i] = 0;   m_anchor[i] = 0; m_cnt[i] = 0;
            m_loss[i] = 0;   m_flag[i] = 0;   m_val[i] = 0;  m_act[i] = 0;
        end
    endtask

    // One clock of the model: decide on the word seen before the edge, then shift.
    // State 0 = hunting, 1 = confirming, 2 = locked; word phase is the edge
    // count modulo WIDTH relative to the edge where the hunt found its comma.
    task automatic model_edge(input int i, input bit b);
        logic [15:0] w, mask;
        bit bnd, hit, tripped;
        w       = m_word[i];
        mask    = 16'((32'd1 << p_w[i]) - 1);
        hit     = (w == p_comma[i]);
        bnd     = ((m_edge[i] - m_anchor[i]) % p_w[i]) == 0;
        tripped = 0;
        case (m_state[i])
            0: if (hit) begin
                m_anchor[i] = m_edge[i];
                m_cnt[i] = 1;
                if (p_lock[i] == 1) begin m_state[i] = 2; m_act[i] = 1; end
                else m_state[i] = 1;
            end
            1: if (bnd) begin
                if (hit) begin
                    m_cnt[i]++;
                    if (m_cnt[i] >= p_lock[i]) begin m_state[i] = 2; m_act[i] = 1; end
                end else begin
                    m_cnt[i] = 0;
                    m_state[i] = 0;
                end
            end
            default: begin
                if (bnd) begin
`ifdef S2P_RELOCK_EN
                    if (m_flag[i]) begin
                        m_loss[i]++;
                        if (m_loss[i] >= LOSS) tripped = 1;
                    end else begin
                        m_loss[i] = 0;
                    end
`endif
                    m_flag[i] = 0;
                    if (tripped) begin
                        m_state[i] = 0; m_act[i] = 0; m_val[i] = 0;
                        m_loss[i] = 0;  m_cnt[i] = 0;
                    end else begin
                        m_dout[i] = w;
                        m_val[i]  = !hit;
                    end
                end else if (hit) begin
                    m_flag[i] = 1;
                end
            end
        endcase
        m_word[i] = ((w << 1) | 16'(b)) & mask;
        m_edge[i]++;
    endtask

    task automatic tick(input bit b8, input bit b10);
        data8  = b8;
        data10 = b10;
        @(posedge clk_32f);
        #1;
        if (reset) model_reset();
        else begin
            model_edge(0, b8);
            model_edge(1, b10);
        end
    endtask

    function automatic bit has_mis(logic [15:0] pair);
        for (int k = 1; k < 8; k++) if (pair[15-k -: 8] == 8'hBC) return 1;
        return 0;
    endfunction

    // Random data word that cannot form a comma with its neighbours.
    function automatic logic [7:0] pick_data(logic [7:0] prev);
        logic [7:0] w;
        w = 8'hBC;
        while (w == 8'hBC || has_mis({prev, w}) || has_mis({w, 8'hBC}))
            w = 8'($urandom_range(0, 255));
        return w;
    endfunction

    task automatic push8(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) q8.push_back(w[i]);
    endtask

    task automatic push10(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) q10.push_back(w[i]);
    endtask

    task automatic test_lock();
        logic [7:0] d;
        int idx = 0;
        repeat (5) q8.push_back(1'($urandom));
        repeat (4) push8(8'hBC);
        push8(8'hA5); push8(8'h3C);
        d = pick_data(8'h3C);
        push8(d);
        while (q8.size() > 0) begin
            tick(q8.pop_front(), 1'b0);
            idx++;
            checks++;
            if ({dout8, valid8, active8} !== {m_dout[0][7:0], m_val[0], m_act[0]}) begin
                errors++;
                $display("[TB] FAIL lock_model t%0d: got %h/%b/%b want %h/%b/%b", idx,
                         dout8, valid8, active8, m_dout[0][7:0], m_val[0], m_act[0]);
            end
            if (idx == 37 || idx == 38) begin
                checks++;
                if (active8 !== (idx == 38)) begin
                    errors++;
                    $display("[TB] FAIL lock_rise t%0d: got active=%b want %b", idx, active8, idx == 38);
                end
            end
            if (idx == 46 || idx == 54) begin
                checks++;
                if ({dout8, valid8} !== {(idx == 46) ? 8'hA5 : 8'h3C, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL lock_word t%0d: got %h/%b want %h/1", idx, dout8, valid8,
                             (idx == 46) ? 8'hA5 : 8'h3C);
                end
            end
        end
    endtask

    task automatic test_comma_in_data();
        logic [7:0] d1, d2, d3;
        int idx = 0;
        d1 = pick_data(8'h00);
        d2 = pick_data(8'hBC);
        d3 = pick_data(d2);
        push8(d1); push8(8'hBC); push8(d2); push8(d3);
        while (q8.size() > 0) begin
            tick(q8.pop_front(), 1'b0);
            idx++;
            checks++;
            if ({dout8, valid8, active8} !== {m_dout[0][7:0], m_val[0], m_act[0]}) begin
                errors++;
                $display("[TB] FAIL comma_model t%0d: got %h/%b/%b want %h/%b/%b", idx,
                         dout8, valid8, active8, m_dout[0][7:0], m_val[0], m_act[0]);
            end
        end
        if (idx >= 0) begin end
    endtask

    task automatic test_comma_points();
        logic [7:0] d1, d2, d3;
        int idx = 0;
        d1 = pick_data(8'h00);
        d2 = pick_data(8'hBC);
        d3 = pick_data(d2);
        push8(d1); push8(8'hBC); push8(d2); push8(d3);
        while (q8.size() > 0) begin
            tick(q8.pop_front(), 1'b0);
            idx++;
            if (idx == 17) begin
                checks++;
                if ({valid8, active8} !== 2'b01) begin
                    errors++;
                    $display("[TB] FAIL comma_word: got valid=%b active=%b want 0/1", valid8, active8);
                end
            end
            if (idx == 25) begin
                checks++;
                if ({dout8, valid8, active8} !== {d2, 2'b11}) begin
                    errors++;
                    $display("[TB] FAIL after_comma: got %h/%b/%b want %h/1/1", dout8, valid8, active8, d2);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (5) tick(1'($urandom), 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({dout8, valid8, active8, dout10, valid10, active10} !== 22'b0) begin
            errors++;
            $display("[TB] FAIL reset_immediate: got %h/%b/%b %h/%b/%b want all 0",
                     dout8, valid8, active8, dout10, valid10, active10);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'($urandom), 1'($urandom));
            checks++;
            if ({dout8, valid8, active8, dout10, valid10, active10} !== 22'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold c%0d: got %h/%b/%b %h/%b/%b want all 0", i,
                         dout8, valid8, active8, dout10, valid10, active10);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_false_lock();
        logic [7:0] d1, d2;
        int p, idx;
        bit early;
        idx = 0; early = 0;
        p = $urandom_range(1, 7);
        d1 = pick_data(8'hBC);
        d2 = pick_data(d1);
        repeat (3) push8(8'hBC);
        push8(8'h55);
        repeat (p) q8.push_back(1'b0);
        repeat (4) push8(8'hBC);
        push8(d1); push8(d2);
        while (q8.size() > 0) begin
            tick(q8.pop_front(), 1'b0);
            idx++;
            checks++;
            if ({dout8, valid8, active8} !== {m_dout[0][7:0], m_val[0], m_act[0]}) begin
                errors++;
                $display("[TB] FAIL false_model t%0d: got %h/%b/%b want %h/%b/%b", idx,
                         dout8, valid8, active8, m_dout[0][7:0], m_val[0], m_act[0]);
            end
            if (idx <= 64 + p && active8 !== 1'b0) early = 1;
            if (idx == 65 + p) begin
                checks++;
                if (active8 !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL phase_lock: got active=%b want 1 (pad %0d)", active8, p);
                end
            end
            if (idx == 73 + p) begin
                checks++;
                if ({dout8, valid8} !== {d1, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL phase_word: got %h/%b want %h/1", dout8, valid8, d1);
                end
            end
        end
        checks++;
        if (early) begin
            errors++;
            $display("[TB] FAIL false_lock: got active=1 before 4 aligned commas want 0");
        end
    endtask

    task automatic test_width10();
        int idx = 0;
        push10(10'h17C); push10(10'h17C); push10(10'h3FF); push10(10'h000);
        repeat (40) q8.push_back(1'b0);
        while (q10.size() > 0) begin
            tick(q8.pop_front(), q10.pop_front());
            idx++;
            checks++;
            if ({dout8, valid8, active8, dout10, valid10, active10} !==
                {m_dout[0][7:0], m_val[0], m_act[0], m_dout[1][9:0], m_val[1], m_act[1]}) begin
                errors++;
                $display("[TB] FAIL w10_model t%0d: got %h/%b/%b want %h/%b/%b", idx,
                         dout10, valid10, active10, m_dout[1][9:0], m_val[1], m_act[1]);
            end
            if (idx == 20 || idx == 21) begin
                checks++;
                if (active10 !== (idx == 21)) begin
                    errors++;
                    $display("[TB] FAIL w10_rise t%0d: got active=%b want %b", idx, active10, idx == 21);
                end
            end
            if (idx == 31) begin
                checks++;
                if ({dout10, valid10} !== {10'h3FF, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL w10_word: got %h/%b want 3ff/1", dout10, valid10);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        for (int t = 0; t < 240; t++) begin
            tick(1'($urandom), 1'($urandom));
            checks++;
            if ({dout8, valid8, active8, dout10, valid10, active10} !==
                {m_dout[0][7:0], m_val[0], m_act[0], m_dout[1][9:0], m_val[1], m_act[1]}) begin
                errors++;
                $display("[TB] FAIL random t%0d: got %h/%b/%b %h/%b/%b want %h/%b/%b %h/%b/%b", t,
                         dout8, valid8, active8, dout10, valid10, active10,
                         m_dout[0][7:0], m_val[0], m_act[0], m_dout[1][9:0], m_val[1], m_act[1]);
            end
        end
    endtask

`ifdef S2P_RELOCK_EN
    task automatic test_relock();
        logic [7:0] d1;
        int idx = 0;
        bit fell = 0;
        reset = 1'b1;
        tick(1'b0, 1'b0);
        reset = 1'b0;
        d1 = pick_data(8'hBC);
        repeat (4) push8(8'hBC);
        push8(d1);
        repeat (3) q8.push_back(1'b0);
        repeat (12) push8(8'hBC);
        while (q8.size() > 0) begin
            tick(q8.pop_front(), 1'b0);
            idx++;
            checks++;
            if ({dout8, valid8, active8} !== {m_dout[0][7:0], m_val[0], m_act[0]}) begin
                errors++;
                $display("[TB] FAIL relock_model t%0d: got %h/%b/%b want %h/%b/%b", idx,
                         dout8, valid8, active8, m_dout[0][7:0], m_val[0], m_act[0]);
            end
            if (idx > 33 && active8 === 1'b0) fell = 1;
            if (idx == 65 || idx == 92) begin
                checks++;
                if (active8 !== (idx == 92)) begin
                    errors++;
                    $display("[TB] FAIL relock_edge t%0d: got active=%b want %b", idx, active8, idx == 92);
                end
            end
        end
        checks++;
        if (!fell || active8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL relock_seq: got fell=%b active=%b want 1/1", fell, active8);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        reset = 1'b0;
        test_lock();
        test_comma_in_data();
        test_comma_points();
        test_reset();
        test_false_lock();
        test_width10();
        test_random_stream();
`ifdef S2P_RELOCK_EN
        test_relock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
